// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART boot loader that writes a framed program image into program memory
// and holds the core in reset until the image checks out.
module prog_loader #(
  parameter int CLK_DIV = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              load_req,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  state_t state, state_nx;

  logic             rxd_m, rxd_s, rxd_d;
  logic             rx_act;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick, byte_valid, frame_err;
  logic [8:0]       remain;
  logic [7:0]       acc, csum_sum;
  logic             start_load, latch_len, write_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  // rx_bit: 0 = start re-check, 1..8 = data LSB first, 9 = stop
  assign rx_tick    = rx_act && (rx_cnt == '0);
  assign byte_valid = rx_tick && (rx_bit == 4'd9) && rxd_s;
  assign frame_err  = rx_tick && (rx_bit == 4'd9) && !rxd_s;
  assign csum_sum   = acc + rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_act   <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (!rx_act) begin
      if (rxd_d && !rxd_s) begin
        rx_act <= 1'b1;
        rx_cnt <= HALF;
        rx_bit <= '0;
      end
    end else if (rx_cnt != '0) begin
      rx_cnt <= rx_cnt - CNT_W'(1);
    end else begin
      rx_cnt <= FULL;
      if (rx_bit == 4'd0) begin
        if (rxd_s) rx_act <= 1'b0;
        else       rx_bit <= 4'd1;
      end else if (rx_bit == 4'd9) begin
        rx_act <= 1'b0;
      end else begin
        rx_shift <= {rxd_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // DATA is left only once the final write strobe has gone out, so pm_we never leaks into CSUM
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (load_req) state_nx = S_HDR;
      S_HDR:  if (frame_err) state_nx = S_ERR;
              else if (byte_valid && rx_shift == 8'hA5) state_nx = S_LEN;
      S_LEN:  if (frame_err) state_nx = S_ERR;
              else if (byte_valid) state_nx = S_DATA;
      S_DATA: if (frame_err) state_nx = S_ERR;
              else if (pm_we && remain == 9'd0) state_nx = S_CSUM;
      S_CSUM: if (frame_err) state_nx = S_ERR;
              else if (byte_valid) state_nx = (csum_sum == 8'd0) ? S_DONE : S_ERR;
      S_DONE: state_nx = S_IDLE;
      S_ERR:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start_load = 1'b0;
    latch_len  = 1'b0;
    write_byte = 1'b0;
    case (state)
      S_IDLE: start_load = load_req;
      S_LEN:  latch_len  = byte_valid;
      S_DATA: write_byte = byte_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      cpu_rst  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      remain   <= '0;
      acc      <= '0;
    end else begin
      pm_we <= write_byte;
      if (pm_we) pm_addr <= pm_addr + ADDR_W'(1);
      if (write_byte) begin
        pm_wdata <= DATA_W'(rx_shift);
        acc      <= csum_sum;
        remain   <= remain - 9'd1;
      end
      if (latch_len) begin
        remain <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
        acc    <= '0;
      end
      if (start_load) begin
        cpu_rst <= 1'b1;
        busy    <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
        pm_addr <= '0;
      end
      if (state == S_DONE) begin
        cpu_rst <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
      if (state == S_ERR) begin
        busy <= 1'b0;
        err  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized bench for prog_loader against a frame-level reference model
module tb_prog_loader;
  localparam int CLK_DIV = 16;
  localparam int R_BUSY = 0, R_DONE = 1, R_ERR = 2;

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, load_req = 1'b0;
  logic       pm_we, cpu_rst, busy, done, err;
  logic [7:0] pm_addr, pm_wdata;

  prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .load_req(load_req),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] got_a[$], got_d[$], exp_a[$], exp_d[$], tx_q[$];
  int tx_bad, exp_res;

  always @(negedge clk) if (!rst && pm_we) begin
    got_a.push_back(pm_addr);
    got_d.push_back(pm_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: locate header, take LEN data bytes, judge checksum, stop at a bad stop bit
  function automatic void model();
    int h, len, k;
    logic [7:0] sum;
    exp_a.delete(); exp_d.delete();
    exp_res = R_BUSY; h = -1; sum = 8'd0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == tx_bad) begin exp_res = R_ERR; return; end
      if (tx_q[i] == 8'hA5) begin h = i; break; end
    end
    if (h < 0 || h + 1 >= tx_q.size()) return;
    if (h + 1 == tx_bad) begin exp_res = R_ERR; return; end
    len = (tx_q[h+1] == 8'd0) ? 256 : int'(tx_q[h+1]);
    for (int j = 0; j < len; j++) begin
      k = h + 2 + j;
      if (k >= tx_q.size()) return;
      if (k == tx_bad) begin exp_res = R_ERR; return; end
      exp_a.push_back(8'(j));
      exp_d.push_back(tx_q[k]);
      sum = sum + tx_q[k];
    end
    k = h + 2 + len;
    if (k >= tx_q.size()) return;
    if (k == tx_bad) begin exp_res = R_ERR; return; end
    exp_res = (8'(sum + tx_q[k]) == 8'd0) ? R_DONE : R_ERR;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (CLK_DIV) @(posedge clk);
    end
    #1 rxd = stop_ok;
    repeat (CLK_DIV) @(posedge clk);
    #1 rxd = 1'b1;
    repeat ($urandom_range(1, CLK_DIV)) @(posedge clk);
  endtask

  task automatic pulse_load(input string tag);
    got_a.delete(); got_d.delete();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    chk({tag, ".busy1"}, busy, 1);
    chk({tag, ".cpurst1"}, cpu_rst, 1);
    chk({tag, ".flags0"}, {done, err}, 0);
    chk({tag, ".addr0"}, pm_addr, 0);
  endtask

  task automatic run_load(input string tag);
    int n;
    model();
    pulse_load(tag);
    for (int k = 0; k < tx_q.size(); k++) begin
      send_byte(tx_q[k], k != tx_bad);
      if (k == tx_bad) break;
    end
    n = 0;
    while (busy && n < 20 * CLK_DIV) begin @(posedge clk); #1; n++; end
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".nwr"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk($sformatf("%s.wa%0d", tag, i), got_a[i], exp_a[i]);
      chk($sformatf("%s.wd%0d", tag, i), got_d[i], exp_d[i]);
    end
    chk({tag, ".done"}, done, exp_res == R_DONE);
    chk({tag, ".err"}, err, exp_res == R_ERR);
    chk({tag, ".cpurst"}, cpu_rst, exp_res != R_DONE);
  endtask

  initial begin
    logic [7:0] b, sum;
    int len;
    #1;
    chk("rst.outs", {pm_we, pm_addr, pm_wdata, cpu_rst, busy, done, err}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("rst.after", {pm_we, cpu_rst, busy, done, err}, 0);

    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A}; tx_bad = -1;
    run_load("t1");
    tx_q = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'h40, 8'hC0}; tx_bad = -1;
    run_load("t2");
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}; tx_bad = -1;
    run_load("t3");
    tx_q = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h80); tx_bad = -1;
    run_load("t4");
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A}; tx_bad = 3;
    run_load("t5");

    for (int r = 0; r < 6; r++) begin
      tx_q.delete(); sum = 8'd0;
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        tx_q.push_back(b);
      end
      len = $urandom_range(1, 6);
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'(len));
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        tx_q.push_back(b);
        sum = sum + b;
      end
      tx_q.push_back(8'(8'd0 - sum + (($urandom % 2) ? 8'd0 : 8'($urandom_range(1, 255)))));
      tx_bad = ($urandom % 4 == 0) ? $urandom_range(0, tx_q.size() - 1) : -1;
      run_load($sformatf("r%0d", r));
    end

    pulse_load("t6");
    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (2 * CLK_DIV) @(posedge clk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    chk("t6.nwr", got_a.size(), 2);
    if (got_d.size() == 2) chk("t6.wd", {got_a[0], got_d[0], got_a[1], got_d[1]}, 32'h005A_01C3);
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    chk("t6.ign.addr", pm_addr, 2);
    chk("t6.ign.busy", {busy, cpu_rst}, 2'b11);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3 * CLK_DIV) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6.rst.outs", {pm_we, pm_addr, pm_wdata, cpu_rst, busy, done, err}, 0);
    #1 rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * CLK_DIV) @(posedge clk);
    #1;
    chk("t6.post", {pm_we, cpu_rst, busy, done, err}, 0);
    chk("t6.post.nwr", got_a.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
